// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin arbiter that shares one shift-add multiplier
// between two requesters. It latches the winner's operands, strobes the
// multiplier (load, then run), waits for completion or a timeout, and returns
// the product with a one-cycle done pulse to the winner.
module mult_arbiter #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 32
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               req0,
    input  logic               req1,
    input  logic [WIDTH-1:0]   a0,
    input  logic [WIDTH-1:0]   b0,
    input  logic [WIDTH-1:0]   a1,
    input  logic [WIDTH-1:0]   b1,
    output logic               done0,
    output logic               done1,
    output logic               err0,
    output logic               err1,
    output logic [2*WIDTH-1:0] result,
    output logic               busy,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    output logic               mul_load,
    output logic               mul_run,
    input  logic               mul_done,
    input  logic [2*WIDTH-1:0] mul_result
);

    // Smallest counter that can hold the value TIMEOUT.
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_WAIT = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   cnt;
    logic               gnt;
    logic               last_grant;

    logic               any_req;
    logic               grant_sel;
    logic               timeout_hit;
    logic               wait_end;

    logic               load_d;
    logic               run_d;
    logic               busy_d;
    logic               done0_d;
    logic               done1_d;
    logic               err0_d;
    logic               err1_d;
    logic [2*WIDTH-1:0] result_d;

    // On a tie the requester that was not served last wins; otherwise the
    // only active requester wins.
    assign any_req     = req0 | req1;
    assign grant_sel   = (req0 && req1) ? ~last_grant : req1;
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
    // mul_done has priority over the timeout in the same cycle.
    assign wait_end    = (state == S_WAIT) && (mul_done || timeout_hit);

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (any_req) next_state = S_LOAD;
            S_LOAD:  next_state = S_RUN;
            S_RUN:   next_state = S_WAIT;
            S_WAIT:  if (wait_end) next_state = S_RESP;
            S_RESP:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Next values of the registered outputs, derived from the upcoming state.
    always_comb begin
        load_d   = (next_state == S_LOAD);
        run_d    = (next_state == S_RUN);
        busy_d   = (next_state != S_IDLE);
        done0_d  = wait_end && !gnt;
        done1_d  = wait_end && gnt;
        err0_d   = wait_end && !gnt && !mul_done;
        err1_d   = wait_end && gnt && !mul_done;
        result_d = result;
        if (wait_end) begin
            result_d = mul_done ? mul_result : '0;
        end
    end

    // Output registers; result holds between done pulses.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            mul_load <= 1'b0;
            mul_run  <= 1'b0;
            busy     <= 1'b0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            err0     <= 1'b0;
            err1     <= 1'b0;
            result   <= '0;
        end else begin
            mul_load <= load_d;
            mul_run  <= run_d;
            busy     <= busy_d;
            done0    <= done0_d;
            done1    <= done1_d;
            err0     <= err0_d;
            err1     <= err1_d;
            result   <= result_d;
        end
    end

    // Grant, operand latch, round-robin history and the WAIT timeout counter.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            gnt        <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        gnt   <= grant_sel;
                        mul_a <= grant_sel ? a1 : a0;
                        mul_b <= grant_sel ? b1 : b0;
                    end
                end
                S_RUN:   cnt <= '0;
                S_WAIT:  cnt <= cnt + 1'b1;
                S_RESP:  last_grant <= gnt;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: randomized scoreboard bench for mult_arbiter. A behavioural
// multiplier answers mul_run after a chosen latency; a request model predicts
// the round-robin winner, product, error flag and latency of every operation.
module tb_mult_arbiter;

    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 32;

    logic               Clk;
    logic               Reset_n;
    logic               req0, req1;
    logic [WIDTH-1:0]   a0, b0, a1, b1;
    logic               done0, done1, err0, err1;
    logic [2*WIDTH-1:0] result;
    logic               busy;
    logic [WIDTH-1:0]   mul_a, mul_b;
    logic               mul_load, mul_run;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_result;

    mult_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .done0(done0), .done1(done1), .err0(err0), .err1(err1),
        .result(result), .busy(busy),
        .mul_a(mul_a), .mul_b(mul_b),
        .mul_load(mul_load), .mul_run(mul_run),
        .mul_done(mul_done), .mul_result(mul_result)
    );

    typedef struct {
        int              who;
        logic            err;
        logic [15:0]     res;
        int              lat;
        logic [7:0]      ea;
        logic [7:0]      eb;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int run_cyc = 0;
    int lat    = 0;     // multiplier latency after mul_run; 0 = never answers
    int hold   = 1;     // cycles mul_done stays high once it fires
    int last_w = 1;     // model of the round-robin history
    bit prev_load = 0;
    bit chk_busy  = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc++;

    // Behavioural multiplier: answers a fixed latency after mul_run.
    initial begin : mult_model
        int cd;
        bit armed;
        int hcnt;
        cd = 0; armed = 0; hcnt = 0;
        mul_done = 1'b0;
        mul_result = '0;
        forever begin
            @(posedge Clk);
            #1;
            if (!Reset_n) begin
                armed = 0; hcnt = 0;
            end else if (mul_run) begin
                armed = (lat > 0);
                cd = lat;
            end else if (armed) begin
                cd--;
            end
            if (armed && cd == 0) begin
                armed = 0;
                hcnt = hold;
            end
            if (hcnt > 0) begin
                mul_done = 1'b1;
                mul_result = 16'(mul_a) * 16'(mul_b);
                hcnt--;
            end else begin
                mul_done = 1'b0;
                mul_result = 16'($urandom);
            end
        end
    end

    // Monitor: pops the scoreboard on every done pulse, checks strobes and busy.
    always @(negedge Clk) begin
        exp_t e;
        if (Reset_n) begin
            if (mul_load) begin
                chk("load_single", 32'(prev_load), 32'd0);
                chk("busy_at_load", 32'(busy), 32'd1);
            end
            if (mul_run) begin
                run_cyc = cyc;
                chk("run_after_load", 32'(prev_load), 32'd1);
            end
            if (chk_busy) begin
                chk("busy_fall", 32'(busy), 32'd0);
                chk_busy = 0;
            end
            if (done0 || done1) begin
                chk("done_exclusive", 32'(done0 && done1), 32'd0);
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("winner", 32'(done1), 32'(e.who));
                    chk("err", 32'(done1 ? err1 : err0), 32'(e.err));
                    chk("err_other", 32'(done1 ? err0 : err1), 32'd0);
                    chk("result", 32'(result), 32'(e.res));
                    chk("latency", 32'(cyc - run_cyc), 32'(e.lat));
                    chk("mul_a", 32'(mul_a), 32'(e.ea));
                    chk("mul_b", 32'(mul_b), 32'(e.eb));
                    chk_busy = 1;
                end
            end else begin
                chk("err_idle", 32'(err0 | err1), 32'd0);
            end
            prev_load = mul_load;
        end else begin
            prev_load = 0;
        end
    end

    // Raise requests (keeping any pending one), predict the outcome, wait for done.
    task automatic run_op(input bit w0, input bit w1, input int lat_v,
                          input bit fixed, input logic [7:0] x0, input logic [7:0] y0,
                          input logic [7:0] x1, input logic [7:0] y1);
        exp_t e;
        int w;
        bit got;
        if (w0 && !req0) begin
            a0 = fixed ? x0 : 8'($urandom);
            b0 = fixed ? y0 : 8'($urandom);
            req0 = 1'b1;
        end
        if (w1 && !req1) begin
            a1 = fixed ? x1 : 8'($urandom);
            b1 = fixed ? y1 : 8'($urandom);
            req1 = 1'b1;
        end
        if (!req0 && !req1) return;
        w = (req0 && req1) ? 1 - last_w : (req1 ? 1 : 0);
        e.who = w;
        e.ea  = (w == 1) ? a1 : a0;
        e.eb  = (w == 1) ? b1 : b0;
        e.err = (lat_v == 0);
        e.res = e.err ? 16'h0 : 16'(e.ea) * 16'(e.eb);
        e.lat = ((lat_v == 0) ? TIMEOUT : lat_v) + 1;
        sb.push_back(e);
        last_w = w;
        lat  = lat_v;
        hold = $urandom_range(1, 3);
        got = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge Clk);
            #1;
            if (done0 || done1) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            chk("done_wait_expired", 32'd0, 32'd1);
            void'(sb.pop_back());
        end
        if (w == 1) req1 = 1'b0;
        else        req0 = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_done"}, 32'({done0, done1}), 32'd0);
        chk({tag, "_err"}, 32'({err0, err1}), 32'd0);
        chk({tag, "_result"}, 32'(result), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_mul_ab"}, 32'({mul_a, mul_b}), 32'd0);
        chk({tag, "_strobes"}, 32'({mul_load, mul_run}), 32'd0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int r;
        bit saw_busy;
        Reset_n = 1'b0;
        req0 = 0; req1 = 0;
        a0 = 0; b0 = 0; a1 = 0; b1 = 0;
        #3;
        check_all_zero("reset");
        repeat (2) @(posedge Clk);
        #1 Reset_n = 1'b1;
        @(posedge Clk);
        #1;

        // Single request: 7 * 6 with the multiplier answering 3 cycles after run.
        run_op(1, 0, 3, 1, 8'h07, 8'h06, 8'h00, 8'h00);
        // Tie after reset: requester 0 first, then the pending requester 1.
        run_op(1, 1, 3, 1, 8'd3, 8'd5, 8'd9, 8'd9);
        run_op(0, 0, 3, 1, 8'd0, 8'd0, 8'd0, 8'd0);
        // Continuous contention: six operations must alternate.
        for (int i = 0; i < 6; i++) run_op(1, 1, $urandom_range(1, 5), 0, 0, 0, 0, 0);
        // Drain whichever request is still pending.
        run_op(0, 0, 2, 0, 0, 0, 0, 0);
        // Timeout on requester 1.
        run_op(0, 1, 0, 1, 8'd0, 8'd0, 8'h12, 8'h34);
        // Done in the final WAIT cycle beats the timeout.
        run_op(1, 0, TIMEOUT, 1, 8'hFF, 8'hFF, 8'd0, 8'd0);
        // Minimum latency.
        run_op(0, 1, 1, 1, 8'd0, 8'd0, 8'h80, 8'h02);

        // Reset during WAIT: no done pulse, then a normal operation.
        @(posedge Clk);
        #1;
        a0 = 8'h11; b0 = 8'h22; lat = 0; req0 = 1'b1;
        saw_busy = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge Clk);
            #1;
            if (busy) saw_busy = 1;
        end
        chk("busy_before_reset", 32'(saw_busy), 32'd1);
        #1 Reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        req0 = 1'b0;
        last_w = 1;
        repeat (3) @(posedge Clk);
        #1;
        check_all_zero("held_reset");
        Reset_n = 1'b1;
        run_op(1, 0, 4, 1, 8'h0C, 8'h0D, 8'd0, 8'd0);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            bit w0, w1;
            w0 = 1'($urandom);
            w1 = 1'($urandom);
            if (!w0 && !w1 && !req0 && !req1) w0 = 1;
            r = $urandom_range(0, 9);
            run_op(w0, w1, (r == 0) ? 0 : (r == 1) ? TIMEOUT : $urandom_range(1, 8), 0, 0, 0, 0, 0);
        end
        run_op(0, 0, 2, 0, 0, 0, 0, 0);

        repeat (5) @(posedge Clk);
        #1;
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
